// File: rtl/button_repeat.sv
// -----------------------------------------------------------------------------
// button_repeat
//
// Turns a clean, debounced button level into one-cycle event pulses:
// a press pulse on an accepted rising edge, a release pulse when that press
// ends, and auto-repeat pulses while the button is held (first one
// HOLD_CYCLES after the press, then every REPEAT_CYCLES).
//
// Ports
//   clk            system clock, the only clock
//   reset          synchronous, active-high reset
//   level          debounced button level, synchronous to clk (1 = pressed)
//   en             event enable; 0 aborts any tracked press silently
//   press_pulse    one-cycle pulse on an accepted press
//   release_pulse  one-cycle pulse on release of an accepted press
//   repeat_pulse   one-cycle auto-repeat pulse
//   held           high while a press is being tracked
//   rep_cnt        repeats in the current press, saturating at 255
//
// States
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no press tracked; waiting for an enabled rising edge
//   HOLD   | press accepted; timing the initial hold delay
//   REPEAT | hold delay elapsed; issuing periodic repeat pulses
// -----------------------------------------------------------------------------
module button_repeat #(
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000,
    parameter int CW            = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       level,
    input  logic       en,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       repeat_pulse,
    output logic       held,
    output logic [7:0] rep_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    // The counter runs down to zero and fires on the cycle it is found at
    // zero, so a load of N-1 gives a pulse spacing of exactly N cycles.
    localparam logic [CW-1:0] HOLD_LOAD   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REPEAT_LOAD = CW'(REPEAT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE     = {{(CW-1){1'b0}}, 1'b1};

    state_t        state_q;
    state_t        state_nxt;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_nxt;
    logic          level_d;
    logic          press_nxt;
    logic          release_nxt;
    logic          repeat_nxt;
    logic          held_nxt;
    logic [7:0]    rep_cnt_nxt;
    logic [7:0]    rep_cnt_inc;
    logic          rise;
    logic          cnt_tc;

    assign rise        = level & ~level_d;
    assign cnt_tc      = (cnt_q == '0);
    assign rep_cnt_inc = (rep_cnt == 8'hFF) ? 8'hFF : rep_cnt + 8'd1;

    always_comb begin
        state_nxt   = state_q;
        cnt_nxt     = cnt_q;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        repeat_nxt  = 1'b0;
        rep_cnt_nxt = rep_cnt;

        if (!en) begin
            // Aborted press: drop straight to IDLE, no release, keep rep_cnt.
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_nxt   = HOLD;
                        cnt_nxt     = HOLD_LOAD;
                        press_nxt   = 1'b1;
                        rep_cnt_nxt = 8'd0;
                    end
                end

                HOLD: begin
                    // Release is checked first so it wins over a repeat
                    // that would fire in the same cycle.
                    if (!level) begin
                        state_nxt   = IDLE;
                        cnt_nxt     = '0;
                        release_nxt = 1'b1;
                    end else if (cnt_tc) begin
                        state_nxt   = REPEAT;
                        cnt_nxt     = REPEAT_LOAD;
                        repeat_nxt  = 1'b1;
                        rep_cnt_nxt = rep_cnt_inc;
                    end else begin
                        cnt_nxt = cnt_q - CNT_ONE;
                    end
                end

                REPEAT: begin
                    if (!level) begin
                        state_nxt   = IDLE;
                        cnt_nxt     = '0;
                        release_nxt = 1'b1;
                    end else if (cnt_tc) begin
                        cnt_nxt     = REPEAT_LOAD;
                        repeat_nxt  = 1'b1;
                        rep_cnt_nxt = rep_cnt_inc;
                    end else begin
                        cnt_nxt = cnt_q - CNT_ONE;
                    end
                end

                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end

        held_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            // Treat the button as already pressed so a button held through
            // reset needs a genuine release/press before it counts.
            level_d       <= 1'b1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
            rep_cnt       <= 8'd0;
        end else begin
            state_q       <= state_nxt;
            cnt_q         <= cnt_nxt;
            level_d       <= level;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
            repeat_pulse  <= repeat_nxt;
            held          <= held_nxt;
            rep_cnt       <= rep_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_button_repeat.sv
module tb_button_repeat;

    localparam int HOLD   = 8;
    localparam int REP    = 4;
    localparam int K_PRESS   = 0;
    localparam int K_RELEASE = 1;
    localparam int K_REPEAT  = 2;

    logic       clk;
    logic       reset;
    logic       level;
    logic       en;
    logic       press_pulse;
    logic       release_pulse;
    logic       repeat_pulse;
    logic       held;
    logic [7:0] rep_cnt;

    typedef struct {
        int kind;
        int cyc;
        int rc;
    } ev_t;

    ev_t exp_q[$];
    int  cyc   = 0;
    int  total = 0;
    int  bad   = 0;

    button_repeat #(
        .HOLD_CYCLES  (HOLD),
        .REPEAT_CYCLES(REP),
        .CW           (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .level        (level),
        .en           (en),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .repeat_pulse (repeat_pulse),
        .held         (held),
        .rep_cnt      (rep_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s at cycle %0d: actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    task automatic push(input int kind, input int c, input int rc);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.rc   = rc;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic goto_cycle(input int c);
        while (cyc < c) tick(1);
    endtask

    // Monitor: every pulse the DUT presents is matched against the queue head.
    always @(negedge clk) begin
        if (press_pulse || release_pulse || repeat_pulse) begin
            int  kind;
            ev_t e;
            kind = press_pulse ? K_PRESS : (release_pulse ? K_RELEASE : K_REPEAT);
            chk("pulse_onehot", $countones({press_pulse, release_pulse, repeat_pulse}), 1);
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse_kind", kind, -1);
            end else begin
                e = exp_q.pop_front();
                chk("event_kind", kind, e.kind);
                chk("event_cycle", cyc, e.cyc);
                chk("event_rep_cnt", int'(rep_cnt), e.rc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int k;
        int rc;

        reset = 1'b1;
        level = 1'b1;
        en    = 1'b1;
        tick(2);
        reset = 1'b0;
        // Button held through reset: nothing may happen.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("reset_outputs_zero",
                int'({press_pulse, release_pulse, repeat_pulse, held, rep_cnt}), 0);
            tick(1);
        end
        level = 1'b0;
        tick(3);

        // Long hold
        t = cyc + 2;
        goto_cycle(t);
        level = 1'b1;
        push(K_PRESS, t + 1, 0);
        for (int i = 0; i < 6; i++) push(K_REPEAT, t + 9 + 4 * i, i + 1);
        push(K_RELEASE, t + 31, 6);
        goto_cycle(t + 1);
        @(negedge clk);
        chk("long_held_start", int'(held), 1);
        goto_cycle(t + 30);
        level = 1'b0;
        @(negedge clk);
        chk("long_held_end", int'(held), 1);
        goto_cycle(t + 31);
        @(negedge clk);
        chk("long_held_after", int'(held), 0);
        goto_cycle(t + 33);
        @(negedge clk);
        chk("long_rep_cnt_idle", int'(rep_cnt), 6);

        // Short press (press clears rep_cnt to 0)
        t = cyc + 3;
        goto_cycle(t);
        level = 1'b1;
        push(K_PRESS, t + 1, 0);
        push(K_RELEASE, t + 6, 0);
        goto_cycle(t + 5);
        level = 1'b0;
        goto_cycle(t + 8);

        // Collision: release beats the repeat due in the same cycle
        t = cyc + 2;
        goto_cycle(t);
        level = 1'b1;
        push(K_PRESS, t + 1, 0);
        push(K_RELEASE, t + 9, 0);
        goto_cycle(t + 8);
        level = 1'b0;
        goto_cycle(t + 12);

        // Enable gating
        t = cyc + 2;
        goto_cycle(t);
        en    = 1'b0;
        level = 1'b1;
        goto_cycle(t + 5);
        en = 1'b1;
        goto_cycle(t + 10);
        @(negedge clk);
        chk("en_late_no_held", int'(held), 0);
        goto_cycle(t + 18);
        level = 1'b0;
        goto_cycle(t + 20);
        level = 1'b1;
        push(K_PRESS, t + 21, 0);
        goto_cycle(t + 21);
        @(negedge clk);
        chk("en_fresh_press_held", int'(held), 1);
        goto_cycle(t + 24);
        level = 1'b0;
        push(K_RELEASE, t + 25, 0);
        goto_cycle(t + 28);

        // en dropped after a repeat: silent abort, rep_cnt kept
        t = cyc + 2;
        goto_cycle(t);
        level = 1'b1;
        push(K_PRESS, t + 1, 0);
        push(K_REPEAT, t + 9, 1);
        goto_cycle(t + 10);
        en = 1'b0;
        @(negedge clk);
        chk("en_drop_held_before", int'(held), 1);
        goto_cycle(t + 11);
        @(negedge clk);
        chk("en_drop_held_after", int'(held), 0);
        goto_cycle(t + 12);
        @(negedge clk);
        chk("en_drop_rep_cnt_kept", int'(rep_cnt), 1);
        goto_cycle(t + 20);
        level = 1'b0;
        goto_cycle(t + 22);
        en = 1'b1;
        goto_cycle(t + 25);

        // Saturation, then reset in REPEAT
        t = cyc + 2;
        goto_cycle(t);
        level = 1'b1;
        push(K_PRESS, t + 1, 0);
        k = 0;
        while (9 + 4 * k <= 1100) begin
            rc = (k + 1 > 255) ? 255 : k + 1;
            push(K_REPEAT, t + 9 + 4 * k, rc);
            k++;
        end
        goto_cycle(t + 1100);
        @(negedge clk);
        chk("sat_rep_cnt", int'(rep_cnt), 255);
        chk("sat_held", int'(held), 1);
        reset = 1'b1;
        goto_cycle(t + 1101);
        reset = 1'b0;
        @(negedge clk);
        chk("midrun_reset_outputs",
            int'({press_pulse, release_pulse, repeat_pulse, held, rep_cnt}), 0);
        tick(3);
        level = 1'b0;
        tick(5);
        @(negedge clk);
        chk("after_reset_no_held", int'(held), 0);
        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
